// File: rtl/regfile_sb.sv
// Eight-entry 16-bit register file with write-to-read bypass and a per-register
// write-pending scoreboard used by decode to stall on RAW hazards.
module regfile_sb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] wd_in,
    input  logic [2:0]  wa_in,
    input  logic        reg_wr_in,
    input  logic [2:0]  rs_addr,
    input  logic [2:0]  rt_addr,
    output logic [15:0] rs_data,
    output logic [15:0] rt_data,
    input  logic        iss_valid,
    input  logic        iss_wr,
    input  logic [2:0]  iss_wa,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        sb_err
);

    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 3;
    localparam int unsigned NREG = 8;
    localparam int unsigned CW   = 2;
    localparam logic [CW-1:0] PC_MAX  = CW'(3);
    localparam logic [CW-1:0] PC_ZERO = CW'(0);
    localparam logic [CW-1:0] PC_ONE  = CW'(1);

    logic [DW-1:0]   regs [NREG];
    logic [CW-1:0]   pc   [NREG];
    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;
    logic [NREG-1:0] ovf;
    logic [NREG-1:0] unf;

    // Per-register issue / writeback strobes and their error conditions.
    always_comb begin
        inc = '0;
        dec = '0;
        ovf = '0;
        unf = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            inc[i] = iss_valid && iss_wr && (iss_wa == AW'(i));
            dec[i] = reg_wr_in && (wa_in == AW'(i));
            ovf[i] = inc[i] && !dec[i] && (pc[i] == PC_MAX);
            unf[i] = dec[i] && !inc[i] && (pc[i] == PC_ZERO);
        end
    end

    // Register storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (reg_wr_in) begin
            regs[wa_in] <= wd_in;
        end
    end

    // Pending counters saturate at both ends; saturation is reported via sb_err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                pc[i] <= PC_ZERO;
            end
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (inc[i] && !dec[i] && !ovf[i]) begin
                    pc[i] <= pc[i] + PC_ONE;
                end else if (dec[i] && !inc[i] && !unf[i]) begin
                    pc[i] <= pc[i] - PC_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_err <= 1'b0;
        end else if ((|ovf) || (|unf)) begin
            sb_err <= 1'b1;
        end
    end

    // Read ports with same-cycle writeback bypass.
    always_comb begin
        rs_data = (reg_wr_in && (wa_in == rs_addr)) ? wd_in : regs[rs_addr];
        rt_data = (reg_wr_in && (wa_in == rt_addr)) ? wd_in : regs[rt_addr];
    end

    // A lone pending write that retires this cycle is covered by the bypass.
    always_comb begin
        rs_busy = (pc[rs_addr] != PC_ZERO) && !((pc[rs_addr] == PC_ONE) && dec[rs_addr]);
        rt_busy = (pc[rt_addr] != PC_ZERO) && !((pc[rt_addr] == PC_ONE) && dec[rt_addr]);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed plan steps followed by random
// traffic, all compared against a behavioural model of the register file.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] wd_in;
    logic [2:0]  wa_in;
    logic        reg_wr_in;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        iss_valid;
    logic        iss_wr;
    logic [2:0]  iss_wa;
    logic        rs_busy;
    logic        rt_busy;
    logic        sb_err;

    int errors = 0;
    int checks = 0;

    // Reference model: register contents, pending-write counts, sticky error.
    int mreg [8];
    int mpc  [8];
    bit merr;

    regfile_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wd_in     (wd_in),
        .wa_in     (wa_in),
        .reg_wr_in (reg_wr_in),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .iss_valid (iss_valid),
        .iss_wr    (iss_wr),
        .iss_wa    (iss_wa),
        .rs_busy   (rs_busy),
        .rt_busy   (rt_busy),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_busy(input int a);
        bit retiring;
        retiring = reg_wr_in && (int'(wa_in) == a);
        return (mpc[a] > 0) && !(mpc[a] == 1 && retiring);
    endfunction

    function automatic int exp_rd(input int a);
        if (reg_wr_in && int'(wa_in) == a) return int'(wd_in);
        return mreg[a];
    endfunction

    // Applies one cycle of inputs, optionally checks outputs before the edge,
    // then advances the model across the edge.
    task automatic step(input bit rst, input bit wr, input int wa, input int wd,
                        input bit iv, input bit iw, input int iwa,
                        input int ra, input int rb, input bit do_chk, input string tag);
        rst_n     = rst;
        reg_wr_in = wr;
        wa_in     = 3'(wa);
        wd_in     = 16'(wd);
        iss_valid = iv;
        iss_wr    = iw;
        iss_wa    = 3'(iwa);
        rs_addr   = 3'(ra);
        rt_addr   = 3'(rb);
        #1;
        if (do_chk) begin
            chk({tag, ".rs_data"}, rs_data, 16'(exp_rd(ra)));
            chk({tag, ".rt_data"}, rt_data, 16'(exp_rd(rb)));
            chk({tag, ".rs_busy"}, 16'(rs_busy), 16'(exp_busy(ra)));
            chk({tag, ".rt_busy"}, 16'(rt_busy), 16'(exp_busy(rb)));
            chk({tag, ".sb_err"},  16'(sb_err),  16'(merr));
        end
        @(posedge clk);
        if (!rst) begin
            foreach (mreg[i]) begin
                mreg[i] = 0;
                mpc[i]  = 0;
            end
            merr = 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                bit up;
                bit dn;
                up = iv && iw && (iwa == i);
                dn = wr && (wa == i);
                if (up && !dn) begin
                    if (mpc[i] == 3) merr = 1'b1;
                    else mpc[i]++;
                end else if (dn && !up) begin
                    if (mpc[i] == 0) merr = 1'b1;
                    else mpc[i]--;
                end
            end
            if (wr) mreg[wa] = wd;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int ra, input int rb, input string tag);
        step(1, 0, 0, 0, 0, 0, 0, ra, rb, 1, tag);
    endtask

    initial begin
        // Reset held for two edges, outputs unknown until then.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        for (int a = 0; a < 8; a += 2) idle(a, a + 1, "reset_read");
        chk("reset_const.sb_err", 16'(sb_err), 16'h0);

        // Write then read.
        step(1, 1, 3, 16'hBEEF, 0, 0, 0, 0, 0, 1, "wr_r3");
        rs_addr = 3'd3;
        rt_addr = 3'd3;
        reg_wr_in = 1'b0;
        #1;
        chk("r3_const.rs", rs_data, 16'hBEEF);
        chk("r3_const.rt", rt_data, 16'hBEEF);
        idle(3, 3, "rd_r3");

        // Same-cycle bypass over a stale value.
        step(1, 1, 5, 16'h0001, 0, 0, 0, 0, 0, 1, "wr_r5_old");
        rs_addr = 3'd5; reg_wr_in = 1'b1; wa_in = 3'd5; wd_in = 16'h1234;
        #1;
        chk("bypass_const.rs", rs_data, 16'h1234);
        step(1, 1, 5, 16'h1234, 0, 0, 0, 5, 5, 1, "bypass_r5");
        idle(5, 0, "rd_r5");

        // Three issues to r2, then three writebacks.
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 1, 1, 2, 2, 2, 1, "iss_r2");
        idle(0, 2, "r2_pc3");
        chk("r2_busy_const", 16'(rt_busy), 16'h1);
        for (int k = 0; k < 3; k++) step(1, 1, 2, 16'h0200 + k, 0, 0, 0, 2, 2, 1, "wb_r2");
        idle(2, 2, "r2_idle");

        // Overflow: fourth issue while three are pending; count must hold at 3.
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 1, 1, 2, 2, 2, 1, "ovf_r2");
        idle(2, 2, "ovf_flag");
        chk("ovf_const.sb_err", 16'(sb_err), 16'h1);
        for (int k = 0; k < 3; k++) step(1, 1, 2, 16'h0A00 + k, 0, 0, 0, 2, 2, 1, "ovf_drain");
        idle(2, 2, "ovf_drained");

        // Underflow on r6 right after reset; data still written.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        step(1, 1, 6, 16'h6666, 0, 0, 0, 6, 6, 1, "unf_r6");
        idle(6, 6, "unf_flag");
        chk("unf_const.sb_err", 16'(sb_err), 16'h1);
        chk("unf_const.r6", rs_data, 16'h6666);

        // Simultaneous issue and writeback to one register leaves the count alone.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        step(1, 0, 0, 0, 1, 1, 4, 4, 4, 1, "iss_r4");
        step(1, 1, 4, 16'h4444, 1, 1, 4, 4, 4, 1, "iss_wb_r4");
        idle(4, 4, "r4_pend");
        step(1, 1, 4, 16'h4445, 0, 0, 0, 4, 4, 1, "wb_r4");

        // Reset mid-flight with two writes pending on r1.
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 1, 1, 1, 1, 1, 1, "iss_r1");
        step(1, 1, 1, 16'h00FF, 0, 0, 0, 1, 1, 1, "wb_r1");
        idle(1, 1, "r1_pc2");
        step(0, 0, 0, 0, 1, 1, 1, 1, 1, 1, "rst_mid");
        idle(1, 1, "after_rst");
        chk("rst_mid_const.r1", rs_data, 16'h0000);
        chk("rst_mid_const.busy", 16'(rs_busy), 16'h0);

        // Random traffic, writebacks biased toward registers with pending work.
        for (int n = 0; n < 600; n++) begin
            bit rst;
            bit wr;
            int wa;
            rst = ($urandom_range(0, 79) != 0);
            wa  = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) begin
                for (int j = 0; j < 8; j++) if (mpc[(wa + j) % 8] > 0) begin
                    wa = (wa + j) % 8;
                    break;
                end
            end
            wr = ($urandom_range(0, 1) == 1);
            step(rst, wr, wa, $urandom_range(0, 65535),
                 $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7), 1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
